// File: rtl/udp_rx_port_filter.sv
// UDP receive stage: parses the 8-byte UDP header, filters datagrams on a programmable
// destination-port table, strips header and padding, and reports sideband and drop stats.
module udp_rx_port_filter #(
    parameter int          P_PORT_NUM     = 4,
    parameter int          P_IDX_W        = 2,
    parameter logic [15:0] P_DEFAULT_PORT = 16'h8080,
    parameter int          P_LEN_CHECK    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_wr,
    input  logic [P_IDX_W-1:0] i_cfg_idx,
    input  logic [15:0]        i_cfg_port,
    input  logic               i_cfg_en,
    input  logic [7:0]         i_ip_data,
    input  logic [15:0]        i_ip_len,
    input  logic               i_ip_last,
    input  logic               i_ip_valid,
    output logic [7:0]         o_udp_data,
    output logic               o_udp_valid,
    output logic               o_udp_last,
    output logic [15:0]        o_udp_len,
    output logic [15:0]        o_udp_src_port,
    output logic [P_IDX_W-1:0] o_udp_port_idx,
    output logic               o_err_pulse,
    output logic [15:0]        o_drop_cnt,
    output logic [1:0]         o_fsm_state
);

    // Streams are valid-only: a byte transfers on every cycle its valid is high and there
    // is no backpressure; gaps (valid low) simply freeze the parser.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [15:0] hdr_cnt_q, hdr_cnt_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;

    logic [7:0]         data_d;
    logic               valid_d, last_d, err_d, drop_inc;
    logic [15:0]        udp_len_d, src_port_d, drop_d;
    logic [P_IDX_W-1:0] idx_d;

    logic [15:0]        tbl_port [P_PORT_NUM];
    logic [P_PORT_NUM-1:0] tbl_en;

    logic               match_hit;
    logic [P_IDX_W-1:0] match_idx;
    logic               len_err, accept, pay_last;

    assign o_fsm_state = state_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_PORT_NUM; i++) begin
                tbl_port[i] <= (i == 0) ? P_DEFAULT_PORT : 16'h0000;
            end
            tbl_en <= P_PORT_NUM'(1);
        end else if (i_cfg_wr && (int'(i_cfg_idx) < P_PORT_NUM)) begin
            tbl_port[i_cfg_idx] <= i_cfg_port;
            tbl_en[i_cfg_idx]   <= i_cfg_en;
        end
    end

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = P_PORT_NUM - 1; i >= 0; i--) begin
            if (tbl_en[i] && (tbl_port[i] == dst_q)) begin
                match_hit = 1'b1;
                match_idx = P_IDX_W'(i);
            end
        end
    end

    assign len_err  = (P_LEN_CHECK != 0) && (len_q > i_ip_len);
    assign accept   = match_hit && (len_q >= 16'd9) && !len_err;
    assign pay_last = (pay_cnt_q == o_udp_len - 16'd1);

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        pay_cnt_d  = pay_cnt_q;
        data_d     = o_udp_data;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        err_d      = 1'b0;
        drop_inc   = 1'b0;
        udp_len_d  = o_udp_len;
        src_port_d = o_udp_src_port;
        idx_d      = o_udp_port_idx;

        case (state_q)
            IDLE: begin
                if (i_ip_valid) begin
                    src_d[15:8] = i_ip_data;
                    hdr_cnt_d   = 16'd1;
                    if (i_ip_last) begin
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (i_ip_valid) begin
                    case (hdr_cnt_q)
                        16'd1:   src_d[7:0]  = i_ip_data;
                        16'd2:   dst_d[15:8] = i_ip_data;
                        16'd3:   dst_d[7:0]  = i_ip_data;
                        16'd4:   len_d[15:8] = i_ip_data;
                        16'd5:   len_d[7:0]  = i_ip_data;
                        default: ;
                    endcase
                    if (hdr_cnt_q == 16'd7) begin
                        if (accept) begin
                            udp_len_d  = len_q - 16'd8;
                            src_port_d = src_q;
                            idx_d      = match_idx;
                            pay_cnt_d  = 16'd0;
                            state_d    = i_ip_last ? IDLE : PAYLOAD;
                        end else if (len_q == 16'd8) begin
                            state_d = i_ip_last ? IDLE : DISCARD;
                        end else begin
                            drop_inc = 1'b1;
                            err_d    = len_err;
                            state_d  = i_ip_last ? IDLE : DISCARD;
                        end
                    end else if (i_ip_last) begin
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 16'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (i_ip_valid) begin
                    data_d    = i_ip_data;
                    valid_d   = 1'b1;
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_last) begin
                        last_d  = 1'b1;
                        state_d = i_ip_last ? IDLE : DISCARD;
                    end else if (i_ip_last) begin
                        // IP payload ended before the UDP length was reached.
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (i_ip_valid && i_ip_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        drop_d = o_drop_cnt;
        if (drop_inc && (o_drop_cnt != 16'hFFFF)) begin
            drop_d = o_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            hdr_cnt_q      <= '0;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            pay_cnt_q      <= '0;
            o_udp_data     <= '0;
            o_udp_valid    <= 1'b0;
            o_udp_last     <= 1'b0;
            o_udp_len      <= '0;
            o_udp_src_port <= '0;
            o_udp_port_idx <= '0;
            o_err_pulse    <= 1'b0;
            o_drop_cnt     <= '0;
        end else begin
            state_q        <= state_d;
            hdr_cnt_q      <= hdr_cnt_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            len_q          <= len_d;
            pay_cnt_q      <= pay_cnt_d;
            o_udp_data     <= data_d;
            o_udp_valid    <= valid_d;
            o_udp_last     <= last_d;
            o_udp_len      <= udp_len_d;
            o_udp_src_port <= src_port_d;
            o_udp_port_idx <= idx_d;
            o_err_pulse    <= err_d;
            o_drop_cnt     <= drop_d;
        end
    end

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// Directed bench for udp_rx_port_filter: one length-checked instance and one with the
// length check disabled share the same stimulus.
module tb_udp_rx_port_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_port;
    logic        cfg_en;
    logic [7:0]  ip_data;
    logic [15:0] ip_len;
    logic        ip_last;
    logic        ip_valid;

    logic [7:0]  udp_data, n_data;
    logic        udp_valid, n_valid;
    logic        udp_last, n_last;
    logic [15:0] udp_len, n_len;
    logic [15:0] udp_src, n_src;
    logic [1:0]  udp_idx, n_idx;
    logic        err_pulse, n_err;
    logic [15:0] drop_cnt, n_drop;
    logic [1:0]  fsm_state, n_state;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    logic [8:0]  obs_q[$];
    logic [8:0]  exp_q[$];
    logic [9:0]  obs_nc_q[$];
    logic [9:0]  exp_nc_q[$];
    logic [8:0]  pkt_q[$];
    logic [15:0] plen_q[$];

    always #5 clk = ~clk;

    udp_rx_port_filter #(.P_PORT_NUM(4), .P_IDX_W(2), .P_DEFAULT_PORT(16'h8080), .P_LEN_CHECK(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_wr(cfg_wr), .i_cfg_idx(cfg_idx), .i_cfg_port(cfg_port), .i_cfg_en(cfg_en),
        .i_ip_data(ip_data), .i_ip_len(ip_len), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
        .o_udp_data(udp_data), .o_udp_valid(udp_valid), .o_udp_last(udp_last),
        .o_udp_len(udp_len), .o_udp_src_port(udp_src), .o_udp_port_idx(udp_idx),
        .o_err_pulse(err_pulse), .o_drop_cnt(drop_cnt), .o_fsm_state(fsm_state)
    );

    udp_rx_port_filter #(.P_PORT_NUM(4), .P_IDX_W(2), .P_DEFAULT_PORT(16'h8080), .P_LEN_CHECK(0)) dut_nc (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_wr(cfg_wr), .i_cfg_idx(cfg_idx), .i_cfg_port(cfg_port), .i_cfg_en(cfg_en),
        .i_ip_data(ip_data), .i_ip_len(ip_len), .i_ip_last(ip_last), .i_ip_valid(ip_valid),
        .o_udp_data(n_data), .o_udp_valid(n_valid), .o_udp_last(n_last),
        .o_udp_len(n_len), .o_udp_src_port(n_src), .o_udp_port_idx(n_idx),
        .o_err_pulse(n_err), .o_drop_cnt(n_drop), .o_fsm_state(n_state)
    );

    // Output monitor
    always @(posedge clk) begin
        #1;
        if (udp_valid) obs_q.push_back({udp_last, udp_data});
        if (err_pulse) err_cnt++;
        if (n_valid) obs_nc_q.push_back({n_err, n_last, n_data});
    end

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        obs_nc_q.delete();
        exp_nc_q.delete();
        err_cnt = 0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] port, input logic en);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_port = port; cfg_en = en;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic build_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen,
                             input int npay, input logic [7:0] first, input int total);
        logic [7:0] b [64];
        for (int i = 0; i < 64; i++) b[i] = 8'hEE;
        b[0] = src[15:8];  b[1] = src[7:0];
        b[2] = dst[15:8];  b[3] = dst[7:0];
        b[4] = ulen[15:8]; b[5] = ulen[7:0];
        b[6] = 8'h5C;      b[7] = 8'hC5;
        for (int i = 0; i < npay; i++) b[8+i] = first + 8'(i);
        for (int i = 0; i < total; i++) begin
            pkt_q.push_back({(i == total - 1), b[i]});
            plen_q.push_back(16'(total));
        end
    endtask

    task automatic send_stream();
        while (pkt_q.size() > 0) begin
            @(negedge clk);
            {ip_last, ip_data} = pkt_q.pop_front();
            ip_len   = plen_q.pop_front();
            ip_valid = 1'b1;
        end
        @(negedge clk);
        ip_valid = 1'b0;
        ip_last  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({udp_data, udp_valid, udp_last, udp_len, udp_src, udp_idx, err_pulse, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {udp_data, udp_valid, udp_last, udp_len, udp_src, udp_idx, err_pulse, drop_cnt});
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, want 0", fsm_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_match_padding();
        clear_obs();
        build_pkt(16'h1111, 16'h8080, 16'd12, 4, 8'hA1, 14);
        send_stream();
        exp_q = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL pad_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL pad_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({udp_len, udp_idx, udp_src} !== {16'd4, 2'd0, 16'h1111}) begin
            n_fail++; $display("FAIL pad_sideband: got len=%0d idx=%0d src=%h, want 4 0 1111", udp_len, udp_idx, udp_src);
        end
        n_checks++;
        if (drop_cnt !== 16'd0 || err_cnt !== 0) begin
            n_fail++; $display("FAIL pad_drop: got drop=%0d err=%0d, want 0 0", drop_cnt, err_cnt);
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL pad_idle: got state %0d, want 0", fsm_state);
        end
    endtask

    task automatic test_table_write();
        logic [1:0] want_idx [3];
        want_idx = '{2'd2, 2'd2, 2'd3};
        cfg_write(2'd2, 16'h1234, 1'b1);
        for (int step = 0; step < 3; step++) begin
            if (step == 1) cfg_write(2'd3, 16'h1234, 1'b1);
            if (step == 2) cfg_write(2'd2, 16'h1234, 1'b0);
            clear_obs();
            build_pkt(16'h2222, 16'h1234, 16'd10, 2, 8'hB0, 10);
            send_stream();
            n_checks++;
            if (obs_q.size() !== 2 || obs_q[0] !== 9'h0B0 || obs_q[1] !== 9'h1B1) begin
                n_fail++; $display("FAIL tbl_data%0d: got %0d bytes, want B0 B1", step, obs_q.size());
            end
            n_checks++;
            if ({udp_idx, udp_len} !== {want_idx[step], 16'd2}) begin
                n_fail++; $display("FAIL tbl_idx%0d: got idx=%0d len=%0d, want %0d 2", step, udp_idx, udp_len, want_idx[step]);
            end
        end
        cfg_write(2'd3, 16'h1234, 1'b0);
        clear_obs();
        build_pkt(16'h2222, 16'h1234, 16'd10, 2, 8'hB0, 10);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 0 || drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL tbl_disabled: got %0d bytes drop=%0d, want 0 1", obs_q.size(), drop_cnt);
        end
    endtask

    task automatic test_runt();
        clear_obs();
        build_pkt(16'h3333, 16'h8080, 16'd12, 0, 8'h00, 5);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 0 || err_cnt !== 1 || drop_cnt !== 16'd2) begin
            n_fail++; $display("FAIL runt: got bytes=%0d err=%0d drop=%0d, want 0 1 2", obs_q.size(), err_cnt, drop_cnt);
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL runt_idle: got state %0d, want 0", fsm_state);
        end
        clear_obs();
        build_pkt(16'h3334, 16'h8080, 16'd9, 1, 8'hC5, 9);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== 9'h1C5 || udp_len !== 16'd1 || err_cnt !== 0) begin
            n_fail++; $display("FAIL runt_next: got bytes=%0d len=%0d err=%0d, want 1 byte C5 len 1 err 0", obs_q.size(), udp_len, err_cnt);
        end
    endtask

    task automatic test_len_error();
        clear_obs();
        build_pkt(16'h4444, 16'h8080, 16'd20, 4, 8'hD0, 12);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 0 || err_cnt !== 1 || drop_cnt !== 16'd3) begin
            n_fail++; $display("FAIL lenerr: got bytes=%0d err=%0d drop=%0d, want 0 1 3", obs_q.size(), err_cnt, drop_cnt);
        end
        exp_nc_q = '{10'h0D0, 10'h0D1, 10'h0D2, 10'h3D3};
        n_checks++;
        if (obs_nc_q.size() !== exp_nc_q.size()) begin
            n_fail++; $display("FAIL trunc_count: got %0d bytes, want %0d", obs_nc_q.size(), exp_nc_q.size());
        end
        for (int i = 0; i < exp_nc_q.size() && i < obs_nc_q.size(); i++) begin
            n_checks++;
            if (obs_nc_q[i] !== exp_nc_q[i]) begin
                n_fail++; $display("FAIL trunc_byte%0d: got %h, want %h", i, obs_nc_q[i], exp_nc_q[i]);
            end
        end
        n_checks++;
        if (n_len !== 16'd12) begin
            n_fail++; $display("FAIL trunc_len: got %0d, want 12", n_len);
        end
    endtask

    task automatic test_len8();
        clear_obs();
        build_pkt(16'h5555, 16'h8080, 16'd8, 0, 8'h00, 8);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 0 || err_cnt !== 0 || drop_cnt !== 16'd3) begin
            n_fail++; $display("FAIL len8: got bytes=%0d err=%0d drop=%0d, want 0 0 3", obs_q.size(), err_cnt, drop_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        logic [7:0] e;
        clear_obs();
        build_pkt(16'h6666, 16'h8080, 16'd16, 8, 8'hE0, 16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {ip_last, ip_data} = pkt_q.pop_front();
            ip_len   = plen_q.pop_front();
            ip_valid = 1'b1;
            @(posedge clk);
            #2;
            if (i >= 8) begin
                e = 8'hE0 + 8'(i - 8);
                n_checks++;
                if ({udp_valid, udp_data, udp_last} !== {1'b1, e, (i == 15)}) begin
                    n_fail++; $display("FAIL gap_byte%0d: got v=%b d=%h l=%b, want 1 %h %b", i - 8, udp_valid, udp_data, udp_last, e, (i == 15));
                end
            end
            @(negedge clk);
            ip_valid = 1'b0;
            ip_last  = 1'b0;
            @(posedge clk);
            #2;
            if (i >= 8) begin
                n_checks++;
                if (udp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL gap_idle%0d: got valid %b, want 0", i - 8, udp_valid);
                end
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (udp_len !== 16'd8 || err_cnt !== 0 || drop_cnt !== 16'd3) begin
            n_fail++; $display("FAIL gap_side: got len=%0d err=%0d drop=%0d, want 8 0 3", udp_len, err_cnt, drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        cfg_write(2'd2, 16'h1234, 1'b1);
        build_pkt(16'h7777, 16'h8080, 16'd10, 2, 8'hF0, 10);
        build_pkt(16'h7778, 16'h8080, 16'd11, 3, 8'hF8, 11);
        send_stream();
        exp_q = '{9'h0F0, 9'h1F1, 9'h0F8, 9'h0F9, 9'h1FA};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({udp_src, udp_len} !== {16'h7778, 16'd3}) begin
            n_fail++; $display("FAIL b2b_side: got src=%h len=%0d, want 7778 3", udp_src, udp_len);
        end

        // Abandon a datagram mid-payload with a reset
        build_pkt(16'h7779, 16'h8080, 16'd14, 6, 8'h90, 14);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            {ip_last, ip_data} = pkt_q.pop_front();
            ip_len   = plen_q.pop_front();
            ip_valid = 1'b1;
        end
        pkt_q.delete();
        plen_q.delete();
        @(negedge clk);
        ip_valid = 1'b0;
        ip_last  = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if ({udp_data, udp_valid, udp_last, udp_len, udp_src, udp_idx, err_pulse, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h, want 0",
                     {udp_data, udp_valid, udp_last, udp_len, udp_src, udp_idx, err_pulse, drop_cnt});
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL midrst_state: got %0d, want 0", fsm_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clear_obs();
        build_pkt(16'h7780, 16'h1234, 16'd10, 2, 8'hB0, 10);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 0 || drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midrst_table: got bytes=%0d drop=%0d, want 0 1", obs_q.size(), drop_cnt);
        end
        clear_obs();
        build_pkt(16'h7781, 16'h8080, 16'd9, 1, 8'h5A, 9);
        send_stream();
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== 9'h15A) begin
            n_fail++; $display("FAIL midrst_next: got %0d bytes, want single 5A with last", obs_q.size());
        end
        n_checks++;
        if ({udp_src, udp_len, udp_idx} !== {16'h7781, 16'd1, 2'd0}) begin
            n_fail++; $display("FAIL midrst_side: got src=%h len=%0d idx=%0d, want 7781 1 0", udp_src, udp_len, udp_idx);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_idx  = '0;
        cfg_port = '0;
        cfg_en   = 1'b0;
        ip_data  = '0;
        ip_len   = '0;
        ip_last  = 1'b0;
        ip_valid = 1'b0;
        test_reset();
        test_match_padding();
        test_table_write();
        test_runt();
        test_len_error();
        test_len8();
        test_valid_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
